// File: rtl/ica_demix_engine.sv
// Demixing output stage: buffers DEPTH whitened samples and streams y = W*z per sample on start.
// Define SATURATE_EN to clamp results to the DW-bit signed range instead of wrapping.
module ica_demix_engine #(
  parameter int CH    = 4,
  parameter int DEPTH = 128,
  parameter int DW    = 26,
  parameter int FRAC  = 16
) (
  input  logic                       clk_demix,
  input  logic                       rst_demix,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CH*DW-1:0]           s_data,
  input  logic                       w_we,
  input  logic [$clog2(CH*CH)-1:0]   w_addr,
  input  logic [DW-1:0]              w_data,
  input  logic                       start,
  input  logic                       flush,
  output logic                       full,
  output logic                       busy,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [CH*DW-1:0]           y_data,
  output logic [$clog2(DEPTH)-1:0]   y_idx,
  output logic                       done,
  output logic                       w_err
);
  localparam int IW   = $clog2(DEPTH);
  localparam int JW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [JW-1:0] LAST_MAC = JW'(CH - 1);
  localparam logic signed [DW-1:0] ONE = DW'(1 << FRAC);

  // RUN is split into MAC accumulation, one result-forming cycle, and the output handshake wait
  typedef enum logic [2:0] {S_LOAD, S_HOLD, S_MAC, S_FIN, S_OUT} state_t;

  state_t                 state;
  logic [IW-1:0]          wr_ptr;
  logic [IW-1:0]          rd_ptr;
  logic [JW-1:0]          mac_cnt;
  logic [CH*DW-1:0]       sample_buf [DEPTH];
  logic signed [DW-1:0]   w_mat [CH*CH];
  logic signed [ACCW-1:0] acc [CH];
  logic [CH*DW-1:0]       z_vec;
  logic signed [DW-1:0]   z_j;
  logic signed [PW-1:0]   prod [CH];
  logic [CH*DW-1:0]       y_next;

  always_ff @(posedge clk_demix) begin
    if (state == S_LOAD && s_valid && !flush)
      sample_buf[wr_ptr] <= s_data;
  end

  always_comb begin
    z_vec = sample_buf[rd_ptr];
    z_j   = z_vec[int'(mac_cnt)*DW +: DW];
    for (int i = 0; i < CH; i++)
      prod[i] = w_mat[i*CH + int'(mac_cnt)] * z_j;
  end

`ifdef SATURATE_EN
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [ACCW-1:0] shifted [CH];

  always_comb begin
    y_next = '0;
    for (int i = 0; i < CH; i++) begin
      shifted[i] = acc[i] >>> FRAC;
      if (shifted[i] > MAXV)
        y_next[i*DW +: DW] = MAXV[DW-1:0];
      else if (shifted[i] < MINV)
        y_next[i*DW +: DW] = MINV[DW-1:0];
      else
        y_next[i*DW +: DW] = shifted[i][DW-1:0];
    end
  end
`else
  // Taking DW bits starting at FRAC is the arithmetic shift followed by a two's-complement wrap
  always_comb begin
    y_next = '0;
    for (int i = 0; i < CH; i++)
      y_next[i*DW +: DW] = acc[i][FRAC +: DW];
  end
`endif

  always_ff @(posedge clk_demix or posedge rst_demix) begin
    if (rst_demix) begin
      state   <= S_LOAD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mac_cnt <= '0;
      s_ready <= 1'b1;
      full    <= 1'b0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      done    <= 1'b0;
      w_err   <= 1'b0;
      y_data  <= '0;
      y_idx   <= '0;
      for (int i = 0; i < CH; i++)
        acc[i] <= '0;
      for (int k = 0; k < CH*CH; k++)
        w_mat[k] <= (k / CH == k % CH) ? ONE : '0;
    end else begin
      done  <= 1'b0;
      w_err <= 1'b0;
      if (flush) begin
        state   <= S_LOAD;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        mac_cnt <= '0;
        s_ready <= 1'b1;
        full    <= 1'b0;
        busy    <= 1'b0;
        y_valid <= 1'b0;
      end else begin
        // Coefficients may change only between runs so one run never mixes two matrices
        if (w_we) begin
          if (busy)
            w_err <= 1'b1;
          else
            w_mat[w_addr] <= w_data;
        end
        case (state)
          S_LOAD: begin
            if (s_valid) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (wr_ptr == LAST_IDX) begin
                state   <= S_HOLD;
                wr_ptr  <= '0;
                s_ready <= 1'b0;
                full    <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (start) begin
              state   <= S_MAC;
              rd_ptr  <= '0;
              mac_cnt <= '0;
              busy    <= 1'b1;
              for (int i = 0; i < CH; i++)
                acc[i] <= '0;
            end
          end
          S_MAC: begin
            for (int i = 0; i < CH; i++)
              acc[i] <= acc[i] + ACCW'(prod[i]);
            mac_cnt <= mac_cnt + 1'b1;
            if (mac_cnt == LAST_MAC)
              state <= S_FIN;
          end
          S_FIN: begin
            y_data  <= y_next;
            y_idx   <= rd_ptr;
            y_valid <= 1'b1;
            state   <= S_OUT;
          end
          S_OUT: begin
            if (y_ready) begin
              y_valid <= 1'b0;
              mac_cnt <= '0;
              for (int i = 0; i < CH; i++)
                acc[i] <= '0;
              if (rd_ptr == LAST_IDX) begin
                state  <= S_HOLD;
                rd_ptr <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                state  <= S_MAC;
                rd_ptr <= rd_ptr + 1'b1;
              end
            end
          end
          default: state <= S_LOAD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ica_demix_engine.sv
// Directed table-driven bench for ica_demix_engine (CH=4, DEPTH=8, DW=26, FRAC=16).
module tb_ica_demix_engine;
  localparam int CH = 4, DEPTH = 8, DW = 26, FRAC = 16, VW = CH * DW;
`ifdef SATURATE_EN
  localparam longint BIGP = (1 << 25) - 1;
  localparam longint BIGN = -(1 << 25);
`else
  localparam longint BIGP = 0;
  localparam longint BIGN = 0;
`endif

  logic clk_demix = 1'b0;
  logic rst_demix;
  logic s_valid, s_ready, w_we, start, flush, full, busy, y_valid, y_ready, done, w_err;
  logic [VW-1:0] s_data, y_data;
  logic [3:0] w_addr;
  logic [DW-1:0] w_data;
  logic [2:0] y_idx;

  always #5 clk_demix = ~clk_demix;

  ica_demix_engine #(.CH(CH), .DEPTH(DEPTH), .DW(DW), .FRAC(FRAC)) dut (
    .clk_demix(clk_demix), .rst_demix(rst_demix),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .start(start), .flush(flush), .full(full), .busy(busy),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx),
    .done(done), .w_err(w_err)
  );

  typedef struct {
    logic [VW-1:0] z;
    logic [VW-1:0] y;
  } vec_t;

  vec_t tbl_id[DEPTH], tbl_perm[DEPTH], tbl_half[DEPTH], tbl_big[DEPTH], tbl_w4[DEPTH], cur[DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [VW-1:0] pack4(input longint a, input longint b, input longint c, input longint d);
    return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [VW-1:0] z);
    @(negedge clk_demix);
    s_valid = 1'b1;
    s_data  = z;
    @(posedge clk_demix); #1;
    s_valid = 1'b0;
  endtask

  task automatic writeW(input int addr, input longint val);
    @(negedge clk_demix);
    w_we   = 1'b1;
    w_addr = 4'(addr);
    w_data = val[DW-1:0];
    @(posedge clk_demix); #1;
    w_we = 1'b0;
  endtask

  task automatic clearW();
    for (int a = 0; a < CH*CH; a++) writeW(a, 0);
  endtask

  task automatic loadFrame(input string tag);
    for (int n = 0; n < DEPTH; n++) applyStimulus(cur[n].z);
    checkOutput({tag, " full"}, full, 1);
    checkOutput({tag, " s_ready"}, s_ready, 0);
  endtask

  task automatic runFrame(input string tag, input int stall_idx, input int flush_idx, input bit poke_w);
    int edges;
    @(negedge clk_demix);
    start   = 1'b1;
    y_ready = 1'b1;
    @(posedge clk_demix); #1;
    start = 1'b0;
    edges = 0;
    checkOutput({tag, " busy"}, busy, 1);
    if (poke_w) begin
      w_we = 1'b1; w_addr = 4'd0; w_data = '0;
      @(posedge clk_demix); #1;
      w_we = 1'b0;
      checkOutput({tag, " w_err pulse"}, w_err, 1);
      @(posedge clk_demix); #1;
      checkOutput({tag, " w_err clear"}, w_err, 0);
      edges = 2;
    end
    for (int n = 0; n < DEPTH; n++) begin
      if (n > 0) edges = 0;
      while (!y_valid && edges < 40) begin
        @(posedge clk_demix); #1;
        edges++;
      end
      if (!y_valid) begin
        checkOutput({tag, " y_valid timeout"}, y_valid, 1);
        return;
      end
      if (n == 0) checkOutput({tag, " latency"}, edges, CH + 1);
      checkOutput({tag, " y_idx"}, y_idx, n);
      checkOutput({tag, " y_data"}, y_data, cur[n].y);
      if (n == flush_idx) begin
        y_ready = 1'b0;
        flush   = 1'b1;
        @(posedge clk_demix); #1;
        flush = 1'b0;
        checkOutput({tag, " flush y_valid"}, y_valid, 0);
        checkOutput({tag, " flush busy"}, busy, 0);
        checkOutput({tag, " flush s_ready"}, s_ready, 1);
        checkOutput({tag, " flush full"}, full, 0);
        checkOutput({tag, " flush done"}, done, 0);
        y_ready = 1'b1;
        return;
      end
      if (n == stall_idx) begin
        y_ready = 1'b0;
        repeat (3) begin
          @(posedge clk_demix); #1;
          checkOutput({tag, " stall y_valid"}, y_valid, 1);
          checkOutput({tag, " stall y_idx"}, y_idx, n);
          checkOutput({tag, " stall y_data"}, y_data, cur[n].y);
        end
        y_ready = 1'b1;
      end
      @(posedge clk_demix); #1;
      checkOutput({tag, " done"}, done, (n == DEPTH - 1) ? 1 : 0);
    end
    checkOutput({tag, " end busy"}, busy, 0);
    checkOutput({tag, " end full"}, full, 1);
    @(posedge clk_demix); #1;
    checkOutput({tag, " done one-shot"}, done, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges;
    rst_demix = 1'b1;
    s_valid = 1'b0; s_data = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    start = 1'b0; flush = 1'b0; y_ready = 1'b1;

    for (int n = 0; n < DEPTH; n++) begin
      longint k;
      k = n + 1;
      tbl_id[n].z   = pack4(k * 65536, 2 * k * 65536, -k * 65536, 0);
      tbl_id[n].y   = tbl_id[n].z;
      tbl_perm[n].z = tbl_id[n].z;
      tbl_perm[n].y = pack4(2 * k * 65536, k * 32768, k * 65536, 0);
      tbl_half[n].z = pack4((n + 2) * 65536, (2 * n + 4) * 65536, 7 * 65536, -3 * 65536);
      tbl_half[n].y = pack4((3 * n + 6) * 32768, 0, 0, 0);
      if (n % 2 == 0) begin
        tbl_big[n].z = pack4(1 << 24, 1 << 24, 1 << 24, 1 << 24);
        tbl_big[n].y = pack4(BIGP, 0, 0, 0);
      end else begin
        tbl_big[n].z = pack4(-(1 << 24), -(1 << 24), -(1 << 24), -(1 << 24));
        tbl_big[n].y = pack4(BIGN, 0, 0, 0);
      end
      tbl_w4[n].z = tbl_id[n].z;
      tbl_w4[n].y = pack4(8 * k * 65536, 0, 0, 0);
    end
    tbl_half[7].z = pack4(-1, 0, 5, 5);
    tbl_half[7].y = pack4(-1, 0, 0, 0);

    repeat (2) @(posedge clk_demix);
    #1;
    checkOutput("reset s_ready", s_ready, 1);
    checkOutput("reset full", full, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset y_valid", y_valid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset w_err", w_err, 0);
    checkOutput("reset y_data", y_data, 0);
    checkOutput("reset y_idx", y_idx, 0);
    @(negedge clk_demix);
    rst_demix = 1'b0;

    cur = tbl_id;
    loadFrame("ident");
    runFrame("ident", -1, -1, 1'b0);

    clearW();
    writeW(1, 65536); writeW(4, 32768); writeW(10, -65536);
    writeW(12, 65536); writeW(14, 65536);
    cur = tbl_perm;
    runFrame("perm", 2, -1, 1'b0);

    @(negedge clk_demix);
    start = 1'b1; flush = 1'b1;
    @(posedge clk_demix); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("start+flush busy", busy, 0);
    checkOutput("start+flush s_ready", s_ready, 1);
    checkOutput("start+flush full", full, 0);

    clearW();
    writeW(0, 32768); writeW(1, 32768);
    cur = tbl_half;
    loadFrame("half");
    runFrame("half", -1, -1, 1'b0);

    @(negedge clk_demix);
    flush = 1'b1;
    @(posedge clk_demix); #1;
    flush = 1'b0;
    for (int a = 0; a < CH; a++) writeW(a, 32'h40000);
    cur = tbl_big;
    loadFrame("big");
    runFrame("big", -1, 3, 1'b1);

    @(negedge clk_demix);
    start = 1'b1;
    @(posedge clk_demix); #1;
    start = 1'b0;
    checkOutput("load start busy", busy, 0);
    checkOutput("load start s_ready", s_ready, 1);
    repeat (6) @(posedge clk_demix);
    #1;
    checkOutput("load start y_valid", y_valid, 0);

    @(negedge clk_demix);
    s_valid = 1'b1; s_data = pack4(99 * 65536, 99 * 65536, 99 * 65536, 99 * 65536); flush = 1'b1;
    @(posedge clk_demix); #1;
    s_valid = 1'b0; flush = 1'b0;
    cur = tbl_w4;
    loadFrame("w4");
    runFrame("w4", -1, -1, 1'b0);

    @(negedge clk_demix);
    start = 1'b1; y_ready = 1'b0;
    @(posedge clk_demix); #1;
    start = 1'b0;
    edges = 0;
    while (!y_valid && edges < 40) begin
      @(posedge clk_demix); #1;
      edges++;
    end
    checkOutput("pre-reset y_valid", y_valid, 1);
    rst_demix = 1'b1;
    #1;
    checkOutput("async reset y_valid", y_valid, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset y_data", y_data, 0);
    checkOutput("async reset s_ready", s_ready, 1);
    @(negedge clk_demix);
    rst_demix = 1'b0;
    cur = tbl_id;
    loadFrame("post-reset");
    runFrame("post-reset", -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
